// File: rtl/istasyon.sv
// Break-even tracker for a service station: one clock cycle is one operating day,
// income accumulates until it covers the investment or the 31-day window closes.
module istasyon #(
  parameter int unsigned ARAC_SAYISI = 300,
  parameter int unsigned KAR_0       = 6,
  parameter int unsigned KAR_1       = 2,
  parameter int unsigned KAR_2       = 22,
  parameter int unsigned KAR_3       = 9,
  parameter int unsigned YATIRIM     = 21600
) (
  input  logic       saat,
  input  logic       reset,
  input  logic [1:0] islem,
  output logic       amorti,
  output logic [4:0] amorti_gunu
);

  // Declaration initialisers give the all-zero power-up state without a reset pulse.
  logic [4:0]  gun_q         = '0;
  logic [31:0] toplam_q      = '0;
  logic        amorti_q      = 1'b0;
  logic [4:0]  amorti_gunu_q = '0;

  logic [4:0]  gun_d;
  logic [31:0] toplam_d;
  logic        amorti_d;
  logic [4:0]  amorti_gunu_d;

  logic [31:0] kar;
  logic [31:0] gelir;
  logic [31:0] toplamYeni;

  always_comb begin
    kar = KAR_0;
    case (islem)
      2'd0: kar = KAR_0;
      2'd1: kar = KAR_1;
      2'd2: kar = KAR_2;
      2'd3: kar = KAR_3;
      default: kar = KAR_0;
    endcase
    gelir      = ARAC_SAYISI * kar;
    toplamYeni = toplam_q + gelir;
  end

  // Counting stops for good once break-even is reached or day 31 has passed.
  always_comb begin
    gun_d         = gun_q;
    toplam_d      = toplam_q;
    amorti_d      = amorti_q;
    amorti_gunu_d = amorti_gunu_q;
    if (!amorti_q && (gun_q < 5'd31)) begin
      gun_d    = gun_q + 5'd1;
      toplam_d = toplamYeni;
      if (toplamYeni >= YATIRIM) begin
        amorti_d      = 1'b1;
        amorti_gunu_d = gun_q + 5'd1;
      end
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      gun_q         <= '0;
      toplam_q      <= '0;
      amorti_q      <= 1'b0;
      amorti_gunu_q <= '0;
    end else begin
      gun_q         <= gun_d;
      toplam_q      <= toplam_d;
      amorti_q      <= amorti_d;
      amorti_gunu_q <= amorti_gunu_d;
    end
  end

  assign amorti      = amorti_q;
  assign amorti_gunu = amorti_gunu_q;

endmodule

// File: tb/tb_istasyon.sv
// Self-checking bench for istasyon: directed scenarios plus random day sequences,
// each checked against a prefix-sum reference over the history of chosen modes.
module tb_istasyon;

  logic       saat = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] islem = 2'd0;
  logic       amorti;
  logic [4:0] amorti_gunu;

  int compared = 0;
  int mismatched = 0;
  int history[$];
  int income[4] = '{1800, 600, 6600, 2700};

  istasyon dut (
    .saat(saat),
    .reset(reset),
    .islem(islem),
    .amorti(amorti),
    .amorti_gunu(amorti_gunu)
  );

  always #5 saat = ~saat;

  // Expected outcome: first day (within 31) whose running income reaches 21600.
  function automatic logic [5:0] refOutcome();
    int sum = 0;
    for (int i = 0; i < history.size() && i < 31; i++) begin
      sum += income[history[i]];
      if (sum >= 21600) return {1'b1, 5'(i + 1)};
    end
    return 6'd0;
  endfunction

  task automatic checkOutput(input string tag);
    logic [5:0] expd;
    expd = refOutcome();
    compared++;
    assert (amorti === expd[5]) else begin
      mismatched++;
      $error("[TB] FAIL %s amorti: observed %b expected %b (day %0d)", tag, amorti, expd[5], history.size());
    end
    compared++;
    assert (amorti_gunu === expd[4:0]) else begin
      mismatched++;
      $error("[TB] FAIL %s amorti_gunu: observed %0d expected %0d (day %0d)", tag, amorti_gunu, expd[4:0], history.size());
    end
  endtask

  task automatic applyStimulus(input int mode, input string tag);
    islem = 2'(mode);
    @(posedge saat);
    #1;
    history.push_back(mode);
    checkOutput(tag);
  endtask

  task automatic doReset(input int cycles, input string tag);
    reset = 1'b1;
    islem = 2'(cycles);
    repeat (cycles) begin
      @(posedge saat);
      #1;
      history.delete();
      checkOutput(tag);
    end
    reset = 1'b0;
  endtask

  initial begin
    int seq3[7] = '{0, 1, 2, 3, 3, 2, 1};
    #1;
    checkOutput("powerup");

    for (int d = 0; d < 33; d++) applyStimulus((d < 27) ? 1 : 0, "T1");

    doReset(1, "T2rst");
    for (int d = 0; d < 33; d++) applyStimulus(2, "T2");

    doReset(1, "T3rst");
    for (int d = 0; d < 12; d++) applyStimulus(seq3[d % 7], "T3");

    doReset(1, "T4rst");
    for (int d = 0; d < 34; d++) applyStimulus(1, "T4");

    doReset(1, "T5rst");
    for (int d = 0; d < 10; d++) applyStimulus((d % 2 == 0) ? 2 : 1, "T5");

    doReset(2, "T6rst");
    for (int d = 0; d < 10; d++) applyStimulus(3, "T6");

    for (int r = 0; r < 10; r++) begin
      doReset(1, "RNDrst");
      for (int d = 0; d < 34; d++) begin
        if (r % 2 == 1) applyStimulus(int'($urandom_range(0, 1)), "RNDlow");
        else applyStimulus(int'($urandom_range(0, 3)), "RND");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
